// File: rtl/noxygen_flit_pkg.sv
// Shared flit definitions for the NoC injector: type codes, head-field offsets, FSM states.
package noxygen_flit_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic {
        StIdle,
        StPayload
    } state_e;

    // Head layout, MSB first: {type, dest, src, zeros}
    function automatic int head_dest_lsb(int data_width, int type_width, int dest_width);
        return data_width - type_width - dest_width;
    endfunction

    function automatic int head_src_lsb(int data_width, int type_width, int dest_width);
        return data_width - type_width - 2 * dest_width;
    endfunction

endpackage

// File: rtl/packet_injector_if.sv
// Handshake bundle between packet_injector, its message/payload source and the router input port.
interface packet_injector_if #(
    parameter int DEST_WIDTH    = 7,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 30
);
    logic [DEST_WIDTH-1:0]    msg_dest;
    logic                     msg_valid;
    logic                     msg_ready;
    logic [PAYLOAD_WIDTH-1:0] payload_in;
    logic                     payload_valid;
    logic                     payload_ready;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     valid_out;
    logic                     ready_out;
    logic                     busy;

    modport master (
        input  msg_dest, msg_valid, payload_in, payload_valid, ready_out,
        output msg_ready, payload_ready, data_out, valid_out, busy
    );

    modport slave (
        output msg_dest, msg_valid, payload_in, payload_valid, ready_out,
        input  msg_ready, payload_ready, data_out, valid_out, busy
    );
endinterface

// File: rtl/flit_out_reg.sv
// Single-entry valid/ready output register; a new flit may load when empty or draining.
module flit_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_load_ok,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_load_ok = !r_valid || i_ready;
    assign o_data    = r_data;
    assign o_valid   = r_valid;
endmodule

// File: rtl/packet_injector.sv
// NoC TX stage: turns a destination plus payload words into head/body/tail flits for a router port.
// PACKET_INJECTOR_SEQNUM_EN adds an 8-bit packet sequence number in head bits [7:0].
module packet_injector
    import noxygen_flit_pkg::*;
#(
    parameter int  N             = 100,
    parameter int  INDEX         = 1,
    parameter int  DATA_WIDTH    = 32,
    parameter int  TYPE_WIDTH    = 2,
    parameter int  FlitPerPacket = 6,
    localparam int DEST_WIDTH    = $clog2(N),
    localparam int PAYLOAD_WIDTH = DATA_WIDTH - TYPE_WIDTH
) (
    input logic               clk,
    input logic               rst,
    packet_injector_if.master pif
);
    localparam int CNT_WIDTH = $clog2(FlitPerPacket);
    localparam int DEST_LSB  = head_dest_lsb(DATA_WIDTH, TYPE_WIDTH, DEST_WIDTH);
    localparam int SRC_LSB   = head_src_lsb(DATA_WIDTH, TYPE_WIDTH, DEST_WIDTH);

    state_e                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
`ifdef PACKET_INJECTOR_SEQNUM_EN
    logic [7:0]             r_seq;
`endif

    logic                   w_load_ok;
    logic                   w_load;
    logic                   w_msg_hs;
    logic                   w_pay_hs;
    logic                   w_is_tail;
    logic [TYPE_WIDTH-1:0]  w_type;
    logic [DATA_WIDTH-1:0]  w_head;
    logic [DATA_WIDTH-1:0]  w_flit;
    logic [DATA_WIDTH-1:0]  w_data_out;
    logic                   w_valid_out;

    always_comb begin
        w_msg_hs  = (r_state == StIdle) && pif.msg_valid && w_load_ok;
        w_pay_hs  = (r_state == StPayload) && pif.payload_valid && w_load_ok;
        // cnt counts payload words already loaded in this packet
        w_is_tail = int'(r_cnt) >= FlitPerPacket - 2;
        w_type    = w_is_tail ? TYPE_WIDTH'(FLIT_TAIL) : TYPE_WIDTH'(FLIT_BODY);

        w_head                                = '0;
        w_head[DATA_WIDTH-1 -: TYPE_WIDTH]    = TYPE_WIDTH'(FLIT_HEAD);
        w_head[DEST_LSB +: DEST_WIDTH]        = pif.msg_dest;
        w_head[SRC_LSB +: DEST_WIDTH]         = DEST_WIDTH'(INDEX);
`ifdef PACKET_INJECTOR_SEQNUM_EN
        w_head[7:0]                           = r_seq;
`endif

        w_load = w_msg_hs || w_pay_hs;
        w_flit = w_msg_hs ? w_head : {w_type, pif.payload_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
`ifdef PACKET_INJECTOR_SEQNUM_EN
            r_seq   <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_msg_hs) begin
                        r_state <= StPayload;
                        r_cnt   <= '0;
                    end
                end
                StPayload: begin
                    if (w_pay_hs) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (w_is_tail) begin
                            r_state <= StIdle;
`ifdef PACKET_INJECTOR_SEQNUM_EN
                            r_seq   <= r_seq + 8'd1;
`endif
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    flit_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_flit),
        .i_ready  (pif.ready_out),
        .o_load_ok(w_load_ok),
        .o_data   (w_data_out),
        .o_valid  (w_valid_out)
    );

    assign pif.msg_ready     = (r_state == StIdle) && w_load_ok;
    assign pif.payload_ready = (r_state == StPayload) && w_load_ok;
    assign pif.busy          = (r_state == StPayload);
    assign pif.data_out      = w_data_out;
    assign pif.valid_out     = w_valid_out;
endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: reference model of the flit stream plus directed scenarios.
// Honours PACKET_INJECTOR_SEQNUM_EN for head sequence-number expectations.
module tb_packet_injector;
    localparam int DW    = 32;
    localparam int PW    = 30;
    localparam int DESTW = 7;
    localparam int IDX   = 1;
    localparam int FPP   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    packet_injector_if #(.DEST_WIDTH(DESTW), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) pif ();
    packet_injector_if #(.DEST_WIDTH(DESTW), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) pif2 ();

    packet_injector #(
        .N(100), .INDEX(IDX), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .FlitPerPacket(FPP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .pif(pif)
    );

    packet_injector #(
        .N(100), .INDEX(IDX), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .FlitPerPacket(2)
    ) u_dut2 (
        .clk(clk),
        .rst(rst),
        .pif(pif2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Head: type 01 at [31:30], dest at [29:23], src at [22:16], optional seq at [7:0]
    function automatic logic [31:0] exp_head(input int dest, input int seq);
        logic [31:0] h;
        h = 32'h4000_0000 | (32'(dest) << 23) | (32'(IDX) << 16);
`ifdef PACKET_INJECTOR_SEQNUM_EN
        h = h | 32'(seq % 256);
`endif
        return h;
    endfunction

    // Reference model: output register contents and packet progress
    logic        m_v    = 1'b0;
    logic [31:0] m_d    = '0;
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    int          m_seq  = 0;
    int          cyc    = 0;
    logic [31:0] log_d[$];
    int          log_c[$];

    always @(negedge clk) begin
        logic lok;
        logic last;
        cyc++;
        lok = !m_v || pif.ready_out;
        check_eq("valid_out", 64'(pif.valid_out), 64'(m_v));
        if (m_v) check_eq("data_out", 64'(pif.data_out), 64'(m_d));
        check_eq("msg_ready", 64'(pif.msg_ready), 64'(!m_busy && lok));
        check_eq("payload_ready", 64'(pif.payload_ready), 64'(m_busy && lok));
        check_eq("busy", 64'(pif.busy), 64'(m_busy));
        if (pif.valid_out && pif.ready_out) begin
            log_d.push_back(pif.data_out);
            log_c.push_back(cyc);
        end
        if (rst) begin
            m_v = 1'b0; m_d = '0; m_busy = 1'b0; m_cnt = 0; m_seq = 0;
        end else begin
            if (m_v && pif.ready_out) m_v = 1'b0;
            if (!m_busy && pif.msg_valid && lok) begin
                m_d = exp_head(int'(pif.msg_dest), m_seq);
                m_v = 1'b1; m_busy = 1'b1; m_cnt = 0;
            end else if (m_busy && pif.payload_valid && lok) begin
                last = (m_cnt == FPP - 2);
                m_d = {(last ? 2'b11 : 2'b10), pif.payload_in};
                m_v = 1'b1;
                m_cnt++;
                if (last) begin
                    m_busy = 1'b0;
                    m_seq = (m_seq + 1) % 256;
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_log();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic send_msg(input int dest);
        int  n;
        bit  done;
        n = 0; done = 0;
        pif.msg_dest = DESTW'(dest);
        pif.msg_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (pif.msg_ready) done = 1;
            else if (++n > 100) begin
                check_eq("msg_timeout", 64'(0), 64'(1));
                done = 1;
            end
        end
        @(posedge clk); #1;
        pif.msg_valid = 1'b0;
    endtask

    task automatic send_payloads(input int n, input int base);
        int  w;
        bit  done;
        for (int i = 0; i < n; i++) begin
            pif.payload_in = PW'(base + i);
            pif.payload_valid = 1'b1;
            w = 0; done = 0;
            while (!done) begin
                @(negedge clk);
                if (pif.payload_ready) done = 1;
                else if (++w > 100) begin
                    check_eq("payload_timeout", 64'(0), 64'(1));
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        pif.payload_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] f;
        int hc;
        pif.msg_dest = '0; pif.msg_valid = 1'b0; pif.payload_in = '0;
        pif.payload_valid = 1'b0; pif.ready_out = 1'b1;
        pif2.msg_dest = '0; pif2.msg_valid = 1'b0; pif2.payload_in = '0;
        pif2.payload_valid = 1'b0; pif2.ready_out = 1'b1;
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_data_out", 64'(pif.data_out), 64'(0));
        check_eq("rst_valid_out", 64'(pif.valid_out), 64'(0));
        check_eq("rst_busy", 64'(pif.busy), 64'(0));
        check_eq("rst_msg_ready", 64'(pif.msg_ready), 64'(1));
        check_eq("rst_payload_ready", 64'(pif.payload_ready), 64'(0));
        @(posedge clk); #1;

        // Single packet, back-to-back payload
        clear_log();
        send_msg(5);
        send_payloads(5, 1);
        idle_cycles(3);
        check_eq("t1_count", 64'(log_d.size()), 64'(6));
        if (log_d.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                f = log_d[k];
                check_eq("t1_type", 64'(f[31:30]), 64'((k == 0) ? 1 : (k == 5) ? 3 : 2));
                check_eq("t1_cycle", 64'(log_c[k] - log_c[0]), 64'(k));
                if (k > 0) check_eq("t1_payload", 64'(f[29:0]), 64'(k));
            end
            f = log_d[0];
            check_eq("t1_dest", 64'(f[29:23]), 64'(5));
            check_eq("t1_src", 64'(f[22:16]), 64'(1));
        end

        // Backpressure right after the head
        clear_log();
        send_msg(7);
        pif.ready_out = 1'b0;
        pif.payload_in = PW'(16);
        pif.payload_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f = pif.data_out;
            check_eq("t2_hold_pr", 64'(pif.payload_ready), 64'(0));
            check_eq("t2_hold_type", 64'(f[31:30]), 64'(1));
            check_eq("t2_hold_valid", 64'(pif.valid_out), 64'(1));
            @(posedge clk); #1;
        end
        pif.ready_out = 1'b1;
        send_payloads(5, 16);
        idle_cycles(3);
        check_eq("t2_count", 64'(log_d.size()), 64'(6));
        if (log_d.size() == 6) begin
            for (int k = 1; k < 6; k++) begin
                f = log_d[k];
                check_eq("t2_payload", 64'(f[29:0]), 64'(15 + k));
            end
        end

        // Two packets back-to-back
        clear_log();
        send_msg(9);
        send_payloads(5, 32);
        send_msg(10);
        send_payloads(5, 48);
        idle_cycles(3);
        check_eq("t3_count", 64'(log_d.size()), 64'(12));
        if (log_d.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                f = log_d[k];
                check_eq("t3_cycle", 64'(log_c[k] - log_c[0]), 64'(k));
                check_eq("t3_type", 64'(f[31:30]),
                         64'(((k % 6) == 0) ? 1 : ((k % 6) == 5) ? 3 : 2));
            end
            f = log_d[6];
            check_eq("t3_dest2", 64'(f[29:23]), 64'(10));
        end

        // Reset in the middle of a packet
        send_msg(3);
        send_payloads(2, 64);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_valid_out", 64'(pif.valid_out), 64'(0));
        check_eq("t5_busy", 64'(pif.busy), 64'(0));
        check_eq("t5_msg_ready", 64'(pif.msg_ready), 64'(1));
        @(posedge clk); #1;
        clear_log();
        send_msg(4);
        send_payloads(5, 80);
        idle_cycles(3);
        check_eq("t5_count", 64'(log_d.size()), 64'(6));
        if (log_d.size() > 0) begin
            f = log_d[0];
            check_eq("t5_first_type", 64'(f[31:30]), 64'(1));
        end

`ifdef PACKET_INJECTOR_SEQNUM_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        for (int p = 0; p < 257; p++) begin
            send_msg(p % 100);
            send_payloads(5, p);
        end
        idle_cycles(3);
        hc = 0;
        foreach (log_d[k]) begin
            f = log_d[k];
            if (f[31:30] == 2'b01) begin
                check_eq("t6_seq", 64'(f[7:0]), 64'(hc % 256));
                hc++;
            end
        end
        check_eq("t6_heads", 64'(hc), 64'(257));
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) == 0);
            pif.msg_valid = ($urandom_range(0, 3) == 0);
            pif.msg_dest = DESTW'($urandom_range(0, 99));
            pif.payload_valid = ($urandom_range(0, 3) != 0);
            pif.payload_in = PW'($urandom);
            pif.ready_out = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        pif.msg_valid = 1'b0;
        pif.payload_valid = 1'b0;
        pif.ready_out = 1'b1;
        idle_cycles(3);

        // Two-flit packets: first payload word is the tail
        pif2.msg_dest = DESTW'(3);
        pif2.msg_valid = 1'b1;
        @(negedge clk);
        check_eq("t4_msg_ready", 64'(pif2.msg_ready), 64'(1));
        @(posedge clk); #1;
        pif2.msg_valid = 1'b0;
        pif2.payload_in = PW'(32'hABC);
        pif2.payload_valid = 1'b1;
        @(negedge clk);
        f = pif2.data_out;
        check_eq("t4_head_valid", 64'(pif2.valid_out), 64'(1));
        check_eq("t4_head_type", 64'(f[31:30]), 64'(1));
        check_eq("t4_head_dest", 64'(f[29:23]), 64'(3));
        check_eq("t4_busy", 64'(pif2.busy), 64'(1));
        check_eq("t4_payload_ready", 64'(pif2.payload_ready), 64'(1));
        @(posedge clk); #1;
        pif2.payload_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_tail", 64'(pif2.data_out), 64'(32'hC000_0ABC));
        check_eq("t4_tail_valid", 64'(pif2.valid_out), 64'(1));
        check_eq("t4_idle", 64'(pif2.busy), 64'(0));
        check_eq("t4_msg_ready2", 64'(pif2.msg_ready), 64'(1));
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
